jump_branch_unit: RTL and testbench
===================================

Name: jump_branch_unit

Overview:
Decode-stage control-flow resolver for the DLX pipeline. It examines the instruction in decode together with the forwarded rs1 value and PC+4, decides whether control flow is redirected, and produces the redirect target. The combinational result feeds the `control` block's Branch/kill logic in the same cycle. A registered copy is provided for the fetch stage and debug.

Parameters:
- none (DLX encoding fixed: 32-bit instruction, 6-bit opcode, big-endian bit numbering).

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- instruction  input  [0:31]  decode-stage instruction; bit 0 is MSB; opcode = instruction[0:5]
- pc_plus_four  input  [31:0]  address of the sequential next instruction
- rs1  input  [31:0]  forwarded value of register rs1 (instruction[6:10])
- outputPC  output  [31:0]  next PC, combinational
- takeBranch  output  1  redirect required, combinational
- outputPC_q  output  [31:0]  outputPC registered on rising clk
- takeBranch_q  output  1  takeBranch registered on rising clk

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Combinational path, zero latency; no dependence on clk or rst_n:
  - imm16 = sign-extend(instruction[16:31]) to 32 bits.
  - off26 = sign-extend(instruction[6:31]) to 32 bits.
  - Decoding by opcode:
    - 6'h02 J: takeBranch=1; outputPC = pc_plus_four + off26.
    - 6'h03 JAL: takeBranch=1; outputPC = pc_plus_four + off26. The link write is handled by the datapath, not this block.
    - 6'h12 JR: takeBranch=1; outputPC = rs1.
    - 6'h13 JALR: takeBranch=1; outputPC = rs1.
    - 6'h04 BEQZ: takeBranch = (rs1 == 0).
    - 6'h05 BNEZ: takeBranch = (rs1 != 0).
    - For BEQZ/BNEZ: outputPC = pc_plus_four + imm16 when taken, otherwise pc_plus_four.
  - All other opcodes give takeBranch=0 and outputPC=pc_plus_four. This includes R-type 6'h00/6'h01, BFPT/BFPF 6'h06/6'h07 (no FP status input), TRAP 6'h11, RFE 6'h10, loads/stores and ALU immediates.
  - Additions are modulo 2^32 and wrap silently: no overflow detection, no alignment check. The target's low 2 bits pass through unchanged.
  - The outputs must never be X/Z when all inputs are known, since `control` samples takeBranch in an always @(*) block.
- Registered path:
  - On rising clk: outputPC_q <= outputPC and takeBranch_q <= takeBranch.
  - While rst_n=0, regardless of clk: outputPC_q = 32'h0 and takeBranch_q = 0.
  - Reset asserted mid-operation clears both registers immediately. After deassertion, the first rising edge captures the current combinational result.
  - Combinational outputs are unaffected by reset.
- No handshake; no internal state other than the two registers.

Test Plan:
- BEQZ taken: instruction=32'h1020_0010, rs1=0, pc_plus_four=32'h100 -> takeBranch=1, outputPC=32'h110. Same instruction with rs1=5 -> takeBranch=0, outputPC=32'h100.
- BNEZ negative offset: instruction=32'h1420_FFF0, rs1=32'hFFFF_FFFF, pc_plus_four=32'h200 -> takeBranch=1, outputPC=32'h1F0. Same instruction with rs1=0 -> takeBranch=0, outputPC=32'h200.
- J/JAL backward: instruction=32'h0BFF_FFF8 (J, off -8), pc_plus_four=32'h200 -> takeBranch=1, outputPC=32'h1F8. JAL 32'h0C00_0100 with pc_plus_four=32'h40 -> outputPC=32'h140.
- JR/JALR: instruction=32'h4820_0000, rs1=32'h0000_4000 -> takeBranch=1, outputPC=32'h4000. Same check with opcode 6'h13.
- Non-control: ADD 32'h0022_1820, LW 32'h8C22_0004, TRAP 32'h4400_0000 with pc_plus_four=32'h80 -> takeBranch=0, outputPC=32'h80 in all cases. Wrap case: J off +8 with pc_plus_four=32'hFFFF_FFFC -> outputPC=32'h4.
- Registers/reset:
  - After a taken BEQZ, one rising clk -> takeBranch_q=1, outputPC_q=32'h110.
  - Drop rst_n between edges -> both registers 0 immediately, while the combinational outputs are unchanged.
  - Release rst_n, then one rising clk -> the registers hold the current combinational values.

Source files
------------

// File: rtl/jump_branch_unit.sv
// Decode-stage control-flow resolver for the DLX pipeline.
// Produces the redirect decision and target combinationally, plus a registered copy.
module jump_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:31] instruction,
  input  logic [31:0] pc_plus_four,
  input  logic [31:0] rs1,
  output logic [31:0] outputPC,
  output logic        takeBranch,
  output logic [31:0] outputPC_q,
  output logic        takeBranch_q
);

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

  logic [5:0]  w_opcode;
  logic [31:0] w_imm16;
  logic [31:0] w_off26;
  logic [31:0] w_jumpTarget;
  logic [31:0] w_branchTarget;
  logic        w_rs1Zero;
  logic [31:0] w_nextPC;
  logic        w_take;

  // Instruction uses big-endian numbering, so bit 0 is the MSB of each field.
  assign w_opcode       = instruction[0:5];
  assign w_imm16        = {{16{instruction[16]}}, instruction[16:31]};
  assign w_off26        = {{6{instruction[6]}}, instruction[6:31]};
  assign w_jumpTarget   = pc_plus_four + w_off26;
  assign w_branchTarget = pc_plus_four + w_imm16;
  assign w_rs1Zero      = (rs1 == 32'h0);

  always_comb begin
    w_take   = 1'b0;
    w_nextPC = pc_plus_four;
    case (w_opcode)
      OP_J, OP_JAL: begin
        w_take   = 1'b1;
        w_nextPC = w_jumpTarget;
      end
      OP_JR, OP_JALR: begin
        w_take   = 1'b1;
        w_nextPC = rs1;
      end
      OP_BEQZ: begin
        w_take   = w_rs1Zero;
        w_nextPC = w_rs1Zero ? w_branchTarget : pc_plus_four;
      end
      OP_BNEZ: begin
        w_take   = !w_rs1Zero;
        w_nextPC = w_rs1Zero ? pc_plus_four : w_branchTarget;
      end
      default: begin
        w_take   = 1'b0;
        w_nextPC = pc_plus_four;
      end
    endcase
  end

  assign outputPC   = w_nextPC;
  assign takeBranch = w_take;

  logic [31:0] r_outputPC;
  logic        r_takeBranch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outputPC   <= 32'h0;
      r_takeBranch <= 1'b0;
    end else begin
      r_outputPC   <= w_nextPC;
      r_takeBranch <= w_take;
    end
  end

  assign outputPC_q   = r_outputPC;
  assign takeBranch_q = r_takeBranch;

endmodule

// File: tb/tb_jump_branch_unit.sv
// Self-checking bench for jump_branch_unit: directed table, reset sequence,
// and randomized instructions checked against an arithmetic reference model.
module tb_jump_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [0:31] instruction;
  logic [31:0] pc_plus_four;
  logic [31:0] rs1;
  logic [31:0] outputPC;
  logic        takeBranch;
  logic [31:0] outputPC_q;
  logic        takeBranch_q;

  int nVectors = 0;
  int nMiscompares = 0;

  jump_branch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .pc_plus_four (pc_plus_four),
    .rs1          (rs1),
    .outputPC     (outputPC),
    .takeBranch   (takeBranch),
    .outputPC_q   (outputPC_q),
    .takeBranch_q (takeBranch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] expPC;
    logic        expTB;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] r, input logic [31:0] ePC, input logic eTB);
    vec_t v;
    v.name = n; v.instr = i; v.pc = p; v.rs1 = r; v.expPC = ePC; v.expTB = eTB;
    vecs.push_back(v);
  endtask

  // Reference: decode by opcode number with signed integer offsets, mod 2^32.
  function automatic void refModel(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] r, output logic [31:0] ePC,
                                   output logic eTB);
    int unsigned op;
    longint off26;
    longint imm16;
    longint sum;
    op    = instr >> 26;
    off26 = longint'(instr & 32'h03FF_FFFF);
    if (off26 >= 64'd33554432) off26 = off26 - 64'd67108864;
    imm16 = longint'(instr & 32'h0000_FFFF);
    if (imm16 >= 64'd32768) imm16 = imm16 - 64'd65536;
    eTB = 1'b0;
    ePC = pc;
    if (op == 2 || op == 3) begin
      sum = longint'(pc) + off26;
      eTB = 1'b1;
      ePC = 32'(sum);
    end else if (op == 18 || op == 19) begin
      eTB = 1'b1;
      ePC = r;
    end else if ((op == 4 && r == 0) || (op == 5 && r != 0)) begin
      sum = longint'(pc) + imm16;
      eTB = 1'b1;
      ePC = 32'(sum);
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r);
    instruction  = i;
    pc_plus_four = p;
    rs1          = r;
  endtask

  task automatic checkOutput(input string n, input logic [31:0] aPC, input logic aTB,
                             input logic [31:0] ePC, input logic eTB);
    nVectors++;
    if (aPC !== ePC || aTB !== eTB) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got pc=%h take=%b, expected pc=%h take=%b", n, aPC, aTB, ePC, eTB);
    end
  endtask

  logic [31:0] ePC;
  logic        eTB;
  logic [31:0] holdPC;
  logic        holdTB;
  logic [31:0] rnd;
  logic [5:0]  ops [10];

  initial begin
    ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h12, 6'h13, 6'h00, 6'h06, 6'h11, 6'h23};

    addVec("beqz_taken",    32'h1020_0010, 32'h0000_0100, 32'h0,         32'h0000_0110, 1'b1);
    addVec("beqz_not",      32'h1020_0010, 32'h0000_0100, 32'h5,         32'h0000_0100, 1'b0);
    addVec("bnez_neg",      32'h1420_FFF0, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_01F0, 1'b1);
    addVec("bnez_not",      32'h1420_FFF0, 32'h0000_0200, 32'h0,         32'h0000_0200, 1'b0);
    addVec("j_back",        32'h0BFF_FFF8, 32'h0000_0200, 32'h1234,      32'h0000_01F8, 1'b1);
    addVec("jal_fwd",       32'h0C00_0100, 32'h0000_0040, 32'h0,         32'h0000_0140, 1'b1);
    addVec("jr",            32'h4820_0000, 32'h0000_0080, 32'h0000_4000, 32'h0000_4000, 1'b1);
    addVec("jalr",          32'h4C20_0000, 32'h0000_0080, 32'h0000_4000, 32'h0000_4000, 1'b1);
    addVec("add",           32'h0022_1820, 32'h0000_0080, 32'h0,         32'h0000_0080, 1'b0);
    addVec("lw",            32'h8C22_0004, 32'h0000_0080, 32'h0,         32'h0000_0080, 1'b0);
    addVec("trap",          32'h4400_0000, 32'h0000_0080, 32'h0,         32'h0000_0080, 1'b0);
    addVec("bfpt",          32'h1800_0040, 32'h0000_0080, 32'h0,         32'h0000_0080, 1'b0);
    addVec("j_wrap",        32'h0800_0008, 32'hFFFF_FFFC, 32'h0,         32'h0000_0004, 1'b1);
    addVec("jr_unaligned",  32'h4820_0000, 32'h0000_0080, 32'h0000_4003, 32'h0000_4003, 1'b1);

    rst_n = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0);
    #3;
    checkOutput("reset_regs", outputPC_q, takeBranch_q, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].instr, vecs[k].pc, vecs[k].rs1);
      #1;
      checkOutput(vecs[k].name, outputPC, takeBranch, vecs[k].expPC, vecs[k].expTB);
    end

    // Registered path and asynchronous reset sequence.
    @(negedge clk);
    applyStimulus(32'h1020_0010, 32'h0000_0100, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("reg_capture", outputPC_q, takeBranch_q, 32'h0000_0110, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", outputPC_q, takeBranch_q, 32'h0, 1'b0);
    checkOutput("comb_in_reset", outputPC, takeBranch, 32'h0000_0110, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("held_in_reset", outputPC_q, takeBranch_q, 32'h0, 1'b0);
    @(negedge clk);
    applyStimulus(32'h1420_FFF0, 32'h0000_0200, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    #1;
    checkOutput("no_capture_before_edge", outputPC_q, takeBranch_q, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("first_edge_after_reset", outputPC_q, takeBranch_q, 32'h0000_01F0, 1'b1);

    // Randomized instructions against the reference model, both paths.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rnd = $urandom();
      rnd[31:26] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) rnd[31:26] = 6'($urandom());
      applyStimulus(rnd, $urandom(), ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom());
      #1;
      refModel(instruction, pc_plus_four, rs1, ePC, eTB);
      checkOutput("rand_comb", outputPC, takeBranch, ePC, eTB);
      holdPC = ePC;
      holdTB = eTB;
      @(posedge clk);
      #1;
      checkOutput("rand_reg", outputPC_q, takeBranch_q, holdPC, holdTB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
